// File: rtl/hwag_capture_array.sv
// Multi-channel crank/cam input conditioner: synchroniser, counter glitch filter,
// edge qualifier and tooth-period capture with a valid/ack handshake per channel.
`timescale 1ns/1ps

module hwag_capture_ch #(
   parameter int unsigned FLT_W = 14,
   parameter int unsigned TMR_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d,
   input  logic             ena,
   input  logic [1:0]       edge_sel,
   input  logic [FLT_W-1:0] flt_val,
   output logic             filtered,
   output logic             edge_stb,
   output logic [TMR_W-1:0] period,
   output logic             period_vld,
   input  logic             period_ack,
   output logic             ovf,
   output logic             lost
);

   localparam logic [TMR_W-1:0] TMR_MAX = '1;

   logic             s1;
   logic             s2;
   logic [FLT_W-1:0] fcnt;
   logic [FLT_W-1:0] fcnt_nxt;
   logic [TMR_W-1:0] tcnt;
   logic [TMR_W-1:0] tcnt_nxt;
   logic [TMR_W-1:0] period_nxt;
   logic             armed;
   logic             armed_nxt;
   logic             filtered_nxt;
   logic             stb_nxt;
   logic             vld_nxt;
   logic             ovf_nxt;
   logic             lost_nxt;
   logic             flip;
   logic             qual;
   logic             capture;

   // Next-state logic for filter, qualifier, timer and handshake
   always_comb begin
      fcnt_nxt     = fcnt;
      filtered_nxt = filtered;
      stb_nxt      = 1'b0;
      tcnt_nxt     = tcnt;
      armed_nxt    = armed;
      period_nxt   = period;
      vld_nxt      = period_vld;
      ovf_nxt      = ovf;
      lost_nxt     = lost;
      flip         = 1'b0;
      qual         = 1'b0;
      capture      = 1'b0;

      if (!ena) begin
         // Track the pin unfiltered so re-enabling cannot create an edge
         fcnt_nxt     = '0;
         filtered_nxt = s2;
         tcnt_nxt     = '0;
         armed_nxt    = 1'b0;
         vld_nxt      = 1'b0;
         ovf_nxt      = 1'b0;
         lost_nxt     = 1'b0;
      end else begin
         // A threshold lowered below the running count still counts as a match
         if (s2 == filtered) begin
            fcnt_nxt = '0;
         end else if (fcnt >= flt_val) begin
            filtered_nxt = s2;
            fcnt_nxt     = '0;
            flip         = 1'b1;
         end else begin
            fcnt_nxt = fcnt + FLT_W'(1);
         end

         case (edge_sel)
            2'b01:   qual = flip & ~s2;
            2'b10:   qual = flip;
            default: qual = flip & s2;
         endcase
         stb_nxt = qual;

         if (qual) begin
            tcnt_nxt  = '0;
            armed_nxt = 1'b1;
            if (armed) begin
               capture    = 1'b1;
               ovf_nxt    = 1'b0;
               period_nxt = (tcnt == TMR_MAX) ? TMR_MAX : tcnt + TMR_W'(1);
            end
         end else if (armed) begin
            if (tcnt != TMR_MAX) begin
               tcnt_nxt = tcnt + TMR_W'(1);
            end
            ovf_nxt = (tcnt_nxt == TMR_MAX);
         end

         if (capture) begin
            vld_nxt = 1'b1;
            if (period_vld && !period_ack) begin
               lost_nxt = 1'b1;
            end
         end else if (period_ack && period_vld) begin
            vld_nxt  = 1'b0;
            lost_nxt = 1'b0;
         end
      end
   end

   // Channel state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         fcnt       <= '0;
         tcnt       <= '0;
         armed      <= 1'b0;
         filtered   <= 1'b0;
         edge_stb   <= 1'b0;
         period     <= '0;
         period_vld <= 1'b0;
         ovf        <= 1'b0;
         lost       <= 1'b0;
      end else begin
         s1         <= d;
         s2         <= s1;
         fcnt       <= fcnt_nxt;
         tcnt       <= tcnt_nxt;
         armed      <= armed_nxt;
         filtered   <= filtered_nxt;
         edge_stb   <= stb_nxt;
         period     <= period_nxt;
         period_vld <= vld_nxt;
         ovf        <= ovf_nxt;
         lost       <= lost_nxt;
      end
   end

endmodule

module hwag_capture_array #(
   parameter int unsigned CH    = 4,
   parameter int unsigned FLT_W = 14,
   parameter int unsigned TMR_W = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CH-1:0]       d,
   input  logic [CH-1:0]       ena,
   input  logic [2*CH-1:0]     edge_sel,
   input  logic [CH*FLT_W-1:0] flt_val,
   output logic [CH-1:0]       filtered,
   output logic [CH-1:0]       edge_stb,
   output logic [CH*TMR_W-1:0] period,
   output logic [CH-1:0]       period_vld,
   input  logic [CH-1:0]       period_ack,
   output logic [CH-1:0]       ovf,
   output logic [CH-1:0]       lost
);

   // Independent channel slices
   for (genvar i = 0; i < CH; i++) begin : g_ch
      hwag_capture_ch #(
         .FLT_W (FLT_W),
         .TMR_W (TMR_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .d          (d[i]),
         .ena        (ena[i]),
         .edge_sel   (edge_sel[2*i +: 2]),
         .flt_val    (flt_val[i*FLT_W +: FLT_W]),
         .filtered   (filtered[i]),
         .edge_stb   (edge_stb[i]),
         .period     (period[i*TMR_W +: TMR_W]),
         .period_vld (period_vld[i]),
         .period_ack (period_ack[i]),
         .ovf        (ovf[i]),
         .lost       (lost[i])
      );
   end

endmodule

// File: tb/tb_hwag_capture_array.sv
// Bench for hwag_capture_array: timestamp-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps

module tb_hwag_capture_array;

   localparam int CH    = 4;
   localparam int FLT_W = 14;
   localparam int TMR_W = 8;
   localparam int TMAX  = (1 << TMR_W) - 1;

   logic                clk = 1'b0;
   logic                rst;
   logic [CH-1:0]       d;
   logic [CH-1:0]       ena;
   logic [2*CH-1:0]     edge_sel;
   logic [CH*FLT_W-1:0] flt_val;
   logic [CH-1:0]       filtered;
   logic [CH-1:0]       edge_stb;
   logic [CH*TMR_W-1:0] period;
   logic [CH-1:0]       period_vld;
   logic [CH-1:0]       period_ack;
   logic [CH-1:0]       ovf;
   logic [CH-1:0]       lost;

   int checks = 0;
   int passed = 0;

   hwag_capture_array #(.CH(CH), .FLT_W(FLT_W), .TMR_W(TMR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .d          (d),
      .ena        (ena),
      .edge_sel   (edge_sel),
      .flt_val    (flt_val),
      .filtered   (filtered),
      .edge_stb   (edge_stb),
      .period     (period),
      .period_vld (period_vld),
      .period_ack (period_ack),
      .ovf        (ovf),
      .lost       (lost)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   // Model: pin history as a consecutive-mismatch run length, period as cycle
   // distance between qualifying edge timestamps.
   bit     m_s1[CH], m_s2[CH], m_filt[CH], m_stb[CH];
   bit     m_armed[CH], m_pend[CH], m_lost[CH], m_ovf[CH];
   int     m_run[CH], m_per[CH];
   longint m_last[CH];
   longint cyc = 0;

   always @(posedge clk or negedge rst) begin : mdl
      bit         s2o;
      bit         fl;
      bit         cap;
      int         fv;
      longint     el;
      logic [1:0] es;
      if (!rst) begin
         for (int i = 0; i < CH; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_filt[i] = 0; m_stb[i] = 0;
            m_armed[i] = 0; m_pend[i] = 0; m_lost[i] = 0; m_ovf[i] = 0;
            m_run[i] = 0; m_per[i] = 0; m_last[i] = 0;
         end
      end else begin
         cyc++;
         for (int i = 0; i < CH; i++) begin
            s2o = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = d[i];
            if (!ena[i]) begin
               m_filt[i] = s2o; m_run[i] = 0; m_armed[i] = 0; m_pend[i] = 0;
               m_lost[i] = 0; m_ovf[i] = 0; m_stb[i] = 0;
            end else begin
               fv = int'(flt_val[i*FLT_W +: FLT_W]);
               es = edge_sel[2*i +: 2];
               fl = 0;
               if (s2o != m_filt[i]) begin
                  m_run[i]++;
                  if (m_run[i] > fv) begin
                     m_filt[i] = s2o; m_run[i] = 0; fl = 1;
                  end
               end else begin
                  m_run[i] = 0;
               end
               m_stb[i] = fl && (es == 2'b10 || (es == 2'b01 ? !m_filt[i] : m_filt[i]));
               cap = 0;
               if (m_stb[i]) begin
                  if (m_armed[i]) begin
                     el = cyc - m_last[i];
                     m_per[i] = (el > TMAX) ? TMAX : int'(el);
                     cap = 1;
                  end
                  m_armed[i] = 1; m_last[i] = cyc; m_ovf[i] = 0;
               end else if (m_armed[i]) begin
                  m_ovf[i] = (cyc - m_last[i]) >= TMAX;
               end
               if (cap) begin
                  if (m_pend[i] && !period_ack[i]) m_lost[i] = 1;
                  m_pend[i] = 1;
               end else if (period_ack[i] && m_pend[i]) begin
                  m_pend[i] = 0; m_lost[i] = 0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin : cmp
      logic [CH-1:0]       ef, es, ev, eo, el;
      logic [CH*TMR_W-1:0] ep;
      for (int i = 0; i < CH; i++) begin
         ef[i] = m_filt[i]; es[i] = m_stb[i]; ev[i] = m_pend[i];
         eo[i] = m_ovf[i];  el[i] = m_lost[i];
         ep[i*TMR_W +: TMR_W] = TMR_W'(m_per[i]);
      end
      check("filtered", 64'(filtered), 64'(ef));
      check("edge_stb", 64'(edge_stb), 64'(es));
      check("period", 64'(period), 64'(ep));
      check("period_vld", 64'(period_vld), 64'(ev));
      check("ovf", 64'(ovf), 64'(eo));
      check("lost", 64'(lost), 64'(el));
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_stb(input int ch, input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (edge_stb[ch]) cnt++;
      end
   endtask

   function automatic logic [TMR_W-1:0] per_of(input int ch);
      return period[ch*TMR_W +: TMR_W];
   endfunction

   initial begin
      int n;
      int cnt;
      int tot;
      rst = 1'b0; d = '0; ena = '0; edge_sel = '0; flt_val = '0; period_ack = '0;

      // Reset with pins toggling, then release with all channels disabled
      repeat (6) begin @(negedge clk); d = ~d; end
      check("rst_all_zero", 64'({filtered, edge_stb, period_vld, ovf, lost}), 64'd0);
      check("rst_period", 64'(period), 64'd0);
      rst = 1'b1;
      tot = 0;
      repeat (5) begin d = ~d; count_stb(0, 3, cnt); tot += cnt; end
      check("dis_no_stb", 64'(tot), 64'd0);
      d = '0;
      cycles(4);

      // Filter on ch0, threshold 5
      flt_val[0*FLT_W +: FLT_W] = FLT_W'(5);
      ena[0] = 1'b1;
      cycles(4);
      d[0] = 1'b1;
      n = 0;
      while (!filtered[0] && n < 30) begin cycles(1); n++; end
      check("flt_latency", 64'(n), 64'd8);
      check("flt_stb", 64'(edge_stb[0]), 64'd1);
      cycles(12);
      d[0] = 1'b0;
      cycles(20);
      d[0] = 1'b1; cycles(5); d[0] = 1'b0;
      count_stb(0, 20, cnt);
      check("glitch5_rej", 64'(cnt), 64'd0);
      d[0] = 1'b1; cycles(6); d[0] = 1'b0;
      count_stb(0, 30, cnt);
      check("glitch6_acc", 64'(cnt), 64'd1);
      check("glitch6_back", 64'(filtered[0]), 64'd0);

      // Edge select on ch1: falling only, then both
      flt_val[1*FLT_W +: FLT_W] = FLT_W'(2);
      edge_sel[3:2] = 2'b01;
      ena[1] = 1'b1;
      cycles(5);
      tot = 0;
      for (int k = 0; k < 10; k++) begin d[1] = ~d[1]; count_stb(1, 20, cnt); tot += cnt; end
      check("fall_only_cnt", 64'(tot), 64'd5);
      check("fall_period", 64'(per_of(1)), 64'd40);
      check("fall_vld", 64'(period_vld[1]), 64'd1);
      check("model_per1", 64'(m_per[1]), 64'd40);
      edge_sel[3:2] = 2'b10;
      for (int k = 0; k < 4; k++) begin d[1] = ~d[1]; cycles(20); end
      check("both_period", 64'(per_of(1)), 64'd20);

      // Handshake on ch2, edges 100 apart
      ena[2] = 1'b1;
      cycles(5);
      repeat (3) begin d[2] = 1'b1; cycles(10); d[2] = 1'b0; cycles(90); end
      check("hs_period", 64'(per_of(2)), 64'd100);
      check("hs_vld", 64'(period_vld[2]), 64'd1);
      check("hs_lost", 64'(lost[2]), 64'd1);
      d[2] = 1'b1; cycles(2);
      period_ack[2] = 1'b1; cycles(1); period_ack[2] = 1'b0;
      check("hs_coinc_stb", 64'(edge_stb[2]), 64'd1);
      check("hs_coinc_vld", 64'(period_vld[2]), 64'd1);
      check("hs_coinc_lost", 64'(lost[2]), 64'd1);
      cycles(7); d[2] = 1'b0; cycles(20);
      period_ack[2] = 1'b1; cycles(1); period_ack[2] = 1'b0;
      check("hs_ack_vld", 64'(period_vld[2]), 64'd0);
      check("hs_ack_lost", 64'(lost[2]), 64'd0);
      check("model_pend2", 64'(m_pend[2]), 64'd0);

      // Overflow on ch3, edges 300 apart with an 8-bit timer
      ena[3] = 1'b1;
      cycles(5);
      d[3] = 1'b1; cycles(3);
      check("ovf_arm_stb", 64'(edge_stb[3]), 64'd1);
      cycles(254);
      check("ovf_254", 64'(ovf[3]), 64'd0);
      cycles(1);
      check("ovf_255", 64'(ovf[3]), 64'd1);
      d[3] = 1'b0; cycles(42);
      d[3] = 1'b1; cycles(3);
      check("ovf_period", 64'(per_of(3)), 64'd255);
      check("ovf_clear", 64'(ovf[3]), 64'd0);
      check("model_per3", 64'(m_per[3]), 64'd255);

      // Disable/re-enable ch0 mid-run
      flt_val[0*FLT_W +: FLT_W] = '0;
      cycles(10);
      repeat (3) begin d[0] = 1'b1; cycles(10); d[0] = 1'b0; cycles(40); end
      check("en_vld_before", 64'(period_vld[0]), 64'd1);
      check("en_lost_before", 64'(lost[0]), 64'd1);
      ena[0] = 1'b0; cycles(1);
      check("dis_vld", 64'(period_vld[0]), 64'd0);
      check("dis_lost", 64'(lost[0]), 64'd0);
      ena[0] = 1'b1; cycles(5);
      d[0] = 1'b1; cycles(10); d[0] = 1'b0;
      check("reen_arm_only", 64'(period_vld[0]), 64'd0);
      cycles(40);
      d[0] = 1'b1; cycles(10);
      check("reen_vld", 64'(period_vld[0]), 64'd1);
      check("reen_period", 64'(per_of(0)), 64'd50);
      d[0] = 1'b0;

      // Asynchronous reset mid-period
      cycles(17);
      #2 rst = 1'b0;
      #1;
      check("arst_flags", 64'({filtered, edge_stb, period_vld, ovf, lost}), 64'd0);
      check("arst_period", 64'(period), 64'd0);
      cycles(3);
      rst = 1'b1;
      cycles(10);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
